// File: rtl/vga_apb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_apb_pkg
// Brief    : Shared types and constants for the VGA configuration APB master:
//            FSM state encoding, watchdog counter width, default timeout.
// Revision : 1.0 - initial release
// ============================================================================
package vga_apb_pkg;

  // Two-bit FSM state encoding shared by the master
  typedef logic [1:0] apb_state_t;

  localparam apb_state_t ST_IDLE   = 2'd0;
  localparam apb_state_t ST_SETUP  = 2'd1;
  localparam apb_state_t ST_ACCESS = 2'd2;
  localparam apb_state_t ST_RESP   = 2'd3;

  // ACCESS-phase watchdog counter width
  localparam int WDOG_WIDTH = 8;

  // Default number of ACCESS cycles tolerated without pready
  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

endpackage
`default_nettype wire

// File: rtl/vga_apb_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : vga_apb_watchdog
// Brief    : ACCESS-phase wait-state counter. Cleared while the master sits in
//            SETUP, counts every stalled ACCESS cycle, and flags expire once
//            TIMEOUT_CYCLES-1 stalled cycles have been seen. The count
//            saturates at the limit so it can never wrap back to zero.
// Revision : 1.0 - initial release
// ============================================================================
module vga_apb_watchdog
  import vga_apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [WDOG_WIDTH-1:0] LIMIT = WDOG_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [WDOG_WIDTH-1:0] r_count;

  // Stalled-cycle counter: clear has priority, saturate at the limit
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en && (r_count != LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expire = (r_count == LIMIT);

endmodule
`default_nettype wire

// File: rtl/vga_apb_master.sv
`default_nettype none
// ============================================================================
// Module   : vga_apb_master
// Brief    : Single-outstanding APB initiator for the VGA configuration slave.
//            One accepted host request becomes one SETUP/ACCESS transfer; the
//            result is held on the response port until the host takes it.
//            Define VGA_APB_TIMEOUT_EN to add an ACCESS-phase watchdog that
//            aborts a transfer after TIMEOUT_CYCLES cycles without pready.
// Revision : 1.0 - initial release
// ============================================================================
module vga_apb_master
  import vga_apb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  resetn,
  // host request port
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic                  req_write_i,
  // host response port
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_slverr_o,
  output logic                  rsp_timeout_o,
  output logic                  busy_o,
  // APB bus
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  input  logic                  pready_i,
  input  logic                  pslverr_i,
  input  logic [DATA_WIDTH-1:0] prdata_i
);

  apb_state_t r_state;
  apb_state_t w_state_nxt;

  logic w_accept;   // request handshake completes this cycle
  logic w_done;     // slave completes the ACCESS phase this cycle
  logic w_abort;    // watchdog gives up on the ACCESS phase this cycle

`ifdef VGA_APB_TIMEOUT_EN
  logic w_wdog_expire;

  vga_apb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .resetn (resetn),
    .clr    (r_state == ST_SETUP),
    .en     ((r_state == ST_ACCESS) && !pready_i),
    .expire (w_wdog_expire)
  );

  // Completion by the slave wins over a watchdog expiry in the same cycle
  assign w_abort = (r_state == ST_ACCESS) && !pready_i && w_wdog_expire;
`else
  assign w_abort = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (req_valid_i)            w_state_nxt = ST_SETUP;
      ST_SETUP:                              w_state_nxt = ST_ACCESS;
      ST_ACCESS: if (pready_i || w_abort)    w_state_nxt = ST_RESP;
      ST_RESP:   if (rsp_ready_i)            w_state_nxt = ST_IDLE;
      default:                               w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM output decode: handshake strobes and unregistered status
  always_comb begin
    req_ready_o = (r_state == ST_IDLE);
    busy_o      = (r_state != ST_IDLE);
    w_accept    = (r_state == ST_IDLE) && req_valid_i;
    w_done      = (r_state == ST_ACCESS) && pready_i;
  end

  // Registered APB and response outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      paddr_o       <= '0;
      pwdata_o      <= '0;
      pwrite_o      <= 1'b0;
      psel_o        <= 1'b0;
      penable_o     <= 1'b0;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_slverr_o  <= 1'b0;
      rsp_timeout_o <= 1'b0;
    end else begin
      // Request fields are only sampled on acceptance, so they stay put for
      // the whole transfer and linger afterwards in IDLE.
      if (w_accept) begin
        paddr_o  <= req_addr_i;
        pwdata_o <= req_wdata_i;
        pwrite_o <= req_write_i;
        psel_o   <= 1'b1;
      end

      if (r_state == ST_SETUP) begin
        penable_o <= 1'b1;
      end

      if (w_done || w_abort) begin
        psel_o        <= 1'b0;
        penable_o     <= 1'b0;
        rsp_valid_o   <= 1'b1;
        rsp_slverr_o  <= w_done ? pslverr_i : 1'b1;
        rsp_timeout_o <= w_abort;
        rsp_rdata_o   <= (w_done && !pwrite_o) ? prdata_i : '0;
      end

      if ((r_state == ST_RESP) && rsp_ready_i) begin
        rsp_valid_o <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_apb_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_apb_master
// Brief    : Self-checking bench for vga_apb_master. Transfers come from a
//            vector table; expected responses are queued when a request is
//            driven and compared when the response appears. Hand-written
//            sequences cover reset, backpressure and the timeout option.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_apb_master;

  logic        clk;
  logic        resetn;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        req_write_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_slverr_o;
  logic        rsp_timeout_o;
  logic        busy_o;
  logic [31:0] paddr_o;
  logic [31:0] pwdata_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic        pready_i;
  logic        pslverr_i;
  logic [31:0] prdata_i;

  vga_apb_master u_dut (
    .clk           (clk),
    .resetn        (resetn),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_addr_i    (req_addr_i),
    .req_wdata_i   (req_wdata_i),
    .req_write_i   (req_write_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_rdata_o   (rsp_rdata_o),
    .rsp_slverr_o  (rsp_slverr_o),
    .rsp_timeout_o (rsp_timeout_o),
    .busy_o        (busy_o),
    .paddr_o       (paddr_o),
    .pwdata_o      (pwdata_o),
    .psel_o        (psel_o),
    .penable_o     (penable_o),
    .pwrite_o      (pwrite_o),
    .pready_i      (pready_i),
    .pslverr_i     (pslverr_i),
    .prdata_i      (prdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    logic        slverr;
    int          wait_cyc;   // ACCESS cycles with pready low before completion
    int          bp;         // cycles rsp_ready is held low in RESP
    logic [31:0] exp_rdata;
    logic        exp_slverr;
    logic        exp_timeout;
    int          exp_lat;    // cycles from acceptance edge to rsp_valid
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        slverr;
    logic        timeout;
    int          lat;
  } exp_t;

`ifdef VGA_APB_TIMEOUT_EN
  localparam int NV = 8;
`else
  localparam int NV = 7;
`endif

  vec_t vecs [NV];
  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One full transfer: request, slave behaviour, response and release
  task automatic do_txn(input vec_t v);
    exp_t e;
    int   c;
    @(negedge clk);
    chk("req_ready_idle", {63'd0, req_ready_o}, 64'd1);
    req_valid_i = 1'b1;
    req_addr_i  = v.addr;
    req_wdata_i = v.wdata;
    req_write_i = v.write;
    e.rdata   = v.exp_rdata;
    e.slverr  = v.exp_slverr;
    e.timeout = v.exp_timeout;
    e.lat     = v.exp_lat;
    sb.push_back(e);

    @(posedge clk); #1;
    c = 1;
    // Scramble the request port so only latched values can appear on APB
    req_valid_i = 1'b0;
    req_addr_i  = ~v.addr;
    req_wdata_i = ~v.wdata;
    req_write_i = ~v.write;
    chk("setup_psel",    {63'd0, psel_o},      64'd1);
    chk("setup_penable", {63'd0, penable_o},   64'd0);
    chk("setup_paddr",   {32'd0, paddr_o},     {32'd0, v.addr});
    chk("setup_pwdata",  {32'd0, pwdata_o},    {32'd0, v.wdata});
    chk("setup_pwrite",  {63'd0, pwrite_o},    {63'd0, v.write});
    chk("setup_busy",    {63'd0, busy_o},      64'd1);
    chk("setup_req_rdy", {63'd0, req_ready_o}, 64'd0);
    // Junk in SETUP: must not be taken as completion
    pready_i  = 1'b1;
    pslverr_i = 1'b1;
    prdata_i  = 32'hBAD0_0001;

    while (c < 400) begin
      @(posedge clk); #1;
      c++;
      if (rsp_valid_o) break;
      chk("access_sel_en", {62'd0, psel_o, penable_o}, 64'd3);
      chk("access_paddr",  {32'd0, paddr_o},  {32'd0, v.addr});
      chk("access_pwdata", {32'd0, pwdata_o}, {32'd0, v.wdata});
      if (c - 2 == v.wait_cyc) begin
        pready_i  = 1'b1;
        pslverr_i = v.slverr;
        prdata_i  = v.prdata;
      end else begin
        pready_i  = 1'b0;
        pslverr_i = 1'b1;
        prdata_i  = 32'hBAD0_0002;
      end
    end
    if (!rsp_valid_o) begin
      chk("rsp_wait_bound", 64'd0, 64'd1);
      return;
    end

    // Junk in RESP: must be ignored
    pready_i  = 1'b1;
    pslverr_i = 1'b1;
    prdata_i  = 32'hBAD0_0003;
    e = sb.pop_front();
    chk("rsp_latency", 64'(c), 64'(e.lat));
    chk("rsp_rdata",   {32'd0, rsp_rdata_o}, {32'd0, e.rdata});
    chk("rsp_slverr",  {63'd0, rsp_slverr_o},  {63'd0, e.slverr});
    chk("rsp_timeout", {63'd0, rsp_timeout_o}, {63'd0, e.timeout});
    chk("resp_sel_en", {62'd0, psel_o, penable_o}, 64'd0);
    chk("resp_req_rdy", {63'd0, req_ready_o}, 64'd0);

    for (int i = 0; i < v.bp; i++) begin
      // A competing request during RESP must not be taken
      req_valid_i = 1'b1;
      req_addr_i  = 32'hFFFF_FFF0;
      req_wdata_i = 32'h0F0F_0F0F;
      @(posedge clk); #1;
      chk("bp_valid",   {63'd0, rsp_valid_o},  64'd1);
      chk("bp_rdata",   {32'd0, rsp_rdata_o},  {32'd0, e.rdata});
      chk("bp_slverr",  {62'd0, rsp_slverr_o, rsp_timeout_o}, {62'd0, e.slverr, e.timeout});
      chk("bp_req_rdy", {63'd0, req_ready_o},  64'd0);
      chk("bp_paddr",   {32'd0, paddr_o},      {32'd0, v.addr});
    end

    rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b0;
    chk("idle_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
    chk("idle_req_rdy",   {63'd0, req_ready_o}, 64'd1);
    chk("idle_busy",      {63'd0, busy_o},      64'd0);
    chk("idle_paddr",     {32'd0, paddr_o},     {32'd0, v.addr});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit actual=expired required=finish");
    $fatal(1);
  end

  initial begin
    //               wr    addr   wdata          prdata         err  wt  bp  exp_rdata      eerr eto lat
    vecs[0] = '{1'b1, 32'h0, 32'h8000_0000, 32'h5555_5555, 1'b0, 0, 0, 32'h0,         1'b0, 1'b0, 3};
    vecs[1] = '{1'b0, 32'h1, 32'h0,         32'h0000_1234, 1'b0, 3, 0, 32'h0000_1234, 1'b0, 1'b0, 6};
    vecs[2] = '{1'b1, 32'h2, 32'h0000_0003, 32'h7777_7777, 1'b1, 0, 0, 32'h0,         1'b1, 1'b0, 3};
    vecs[3] = '{1'b0, 32'h2, 32'h0,         32'hCAFE_F00D, 1'b1, 1, 5, 32'hCAFE_F00D, 1'b1, 1'b0, 4};
    vecs[4] = '{1'b0, 32'h0, 32'h0,         32'hFFFF_FFFF, 1'b0, 0, 2, 32'hFFFF_FFFF, 1'b0, 1'b0, 3};
    vecs[5] = '{1'b1, 32'h1, 32'h1000_0000, 32'h1111_1111, 1'b0, 2, 5, 32'h0,         1'b0, 1'b0, 5};
`ifdef VGA_APB_TIMEOUT_EN
    // pready in the 16th ACCESS cycle: normal completion wins
    vecs[6] = '{1'b0, 32'h1, 32'h0,         32'h0000_A5A5, 1'b0, 15, 0, 32'h0000_A5A5, 1'b0, 1'b0, 18};
    // pready never comes: abort after 16 ACCESS cycles
    vecs[7] = '{1'b0, 32'h0, 32'h0,         32'h0000_5A5A, 1'b0, 1000, 3, 32'h0,       1'b1, 1'b1, 18};
`else
    // Long stall with no watchdog: still completes normally
    vecs[6] = '{1'b0, 32'h1, 32'h0,         32'h0000_A5A5, 1'b0, 20, 0, 32'h0000_A5A5, 1'b0, 1'b0, 23};
`endif

    resetn      = 1'b0;
    req_valid_i = 1'b0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    req_write_i = 1'b0;
    rsp_ready_i = 1'b0;
    pready_i    = 1'b0;
    pslverr_i   = 1'b0;
    prdata_i    = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_apb_ctrl", {61'd0, psel_o, penable_o, pwrite_o}, 64'd0);
    chk("reset_paddr",    {32'd0, paddr_o}, 64'd0);
    chk("reset_rsp",      {61'd0, rsp_valid_o, rsp_slverr_o, rsp_timeout_o}, 64'd0);
    chk("reset_rdata",    {32'd0, rsp_rdata_o}, 64'd0);
    chk("reset_req_rdy",  {63'd0, req_ready_o}, 64'd1);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      do_txn(vecs[i]);
    end

    // Reset asserted asynchronously in the middle of ACCESS
    @(negedge clk);
    req_valid_i = 1'b1;
    req_addr_i  = 32'h3;
    req_write_i = 1'b0;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    pready_i    = 1'b0;
    @(posedge clk); #1;
    chk("rst_pre_penable", {63'd0, penable_o}, 64'd1);
    #3;
    resetn = 1'b0;
    #1;
    chk("rst_async_sel_en", {62'd0, psel_o, penable_o}, 64'd0);
    chk("rst_async_busy",   {63'd0, busy_o}, 64'd0);
    pready_i = 1'b1;
    @(posedge clk); #1;
    chk("rst_no_rsp", {63'd0, rsp_valid_o}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_after_no_rsp", {63'd0, rsp_valid_o}, 64'd0);
    end
    chk("rst_after_req_rdy", {63'd0, req_ready_o}, 64'd1);

    // Normal operation resumes after reset
    do_txn(vecs[1]);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_apb_master.md
# vga_apb_master

APB initiator that issues single register accesses to the VGA configuration slave on behalf of a host-side command port: resolution select, frame base address and frame top address. It sits between the boot/firmware sequencer and the APB bus and turns one request into one compliant SETUP/ACCESS transfer. It returns read data, error status and completion on a response port.

## Interface
- DATA_WIDTH, 32, APB data width
- ADDR_WIDTH, 32, APB address width
- TIMEOUT_CYCLES, 16, maximum ACCESS-phase cycles without `pready_i`; only used when `VGA_APB_TIMEOUT_EN` is defined; legal range 2..255
- clk  in  1  single clock; all logic on the rising edge
- resetn  in  1  asynchronous assert, active-low reset
- req_valid_i / req_ready_o  in/out  1  request handshake
- req_addr_i  in  ADDR_WIDTH  target register address
- req_wdata_i  in  DATA_WIDTH  write data
- req_write_i  in  1  1 = write, 0 = read
- rsp_valid_o / rsp_ready_i  out/in  1  response handshake
- rsp_rdata_o  out  DATA_WIDTH  read data; 0 for writes
- rsp_slverr_o  out  1  `pslverr_i` captured, or timeout abort
- rsp_timeout_o  out  1  access aborted by watchdog; constant 0 without macro
- busy_o  out  1  state != IDLE
- paddr_o, pwdata_o  out  ADDR_WIDTH, DATA_WIDTH  APB address and write data
- psel_o, penable_o, pwrite_o  out  1  APB control
- pready_i, pslverr_i  in  1  APB completion and error
- prdata_i  in  DATA_WIDTH  APB read data

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. Encoding is in the package.
- IDLE: `req_ready_o` = 1 (combinational from state). A request is accepted when `req_valid_i && req_ready_o`. On acceptance, latch addr, wdata and write into `paddr_o`, `pwdata_o` and `pwrite_o`, and go to SETUP.
- SETUP: `psel_o` = 1, `penable_o` = 0. Unconditional transition to ACCESS.
- ACCESS: `psel_o` = 1, `penable_o` = 1. Stay while `pready_i` = 0.
  - On `pready_i` = 1: capture `pslverr_i`. Capture `prdata_i` for reads; capture 0 for writes. Clear `psel_o` and `penable_o`. Go to RESP.
- RESP: `rsp_valid_o` = 1. Response fields are held stable until `rsp_ready_i`. Then go to IDLE.
- Only one transfer is outstanding; no pipelining. `req_ready_o` = 0 in every state except IDLE.
- `paddr_o`, `pwdata_o` and `pwrite_o` are stable from SETUP through ACCESS completion. They keep their last value in IDLE and change only on acceptance.
- All APB and response outputs are registered, except `req_ready_o` and `busy_o`.
- Reset (async, any state): FSM goes to IDLE; every output register clears to 0, including `psel_o`/`penable_o`. A transfer in flight is dropped and no response is produced.

## Timing
- Acceptance at edge T → SETUP in T+1 → ACCESS in T+2.
- If `pready_i` = 1 in the first ACCESS cycle, `rsp_valid_o` = 1 in T+3.
- Each wait state adds one cycle.
- If `rsp_ready_i` is high in the first RESP cycle, IDLE is reached at T+4. Minimum request-to-request spacing is 4 cycles.
- `pready_i` and `pslverr_i` are sampled only in ACCESS; they are ignored in IDLE, SETUP and RESP.

## Configuration
- `VGA_APB_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entering ACCESS and increments each ACCESS cycle with `pready_i` = 0.
  - When it reaches TIMEOUT_CYCLES−1 with `pready_i` still 0: abort. Drop `psel_o`/`penable_o`, go to RESP with `rsp_slverr_o` = 1, `rsp_timeout_o` = 1, `rsp_rdata_o` = 0.
  - If `pready_i` = 1 in the limit cycle, the normal completion wins and `rsp_timeout_o` = 0.
- Not defined: no counter logic; ACCESS waits indefinitely; `rsp_timeout_o` tied 0.

## Structure
- Package `vga_apb_pkg`: FSM state typedef (2-bit), timeout counter width constant (8), default TIMEOUT_CYCLES.
- Sub-module `vga_apb_watchdog`: the timeout counter with clear, enable and expire ports. It is instantiated only under `VGA_APB_TIMEOUT_EN`.

## Test plan
- Write: addr 0x0, wdata 0x8000_0000, `pready_i` high in the first ACCESS cycle → `psel_o` at T+1, `penable_o` at T+2, `rsp_valid_o` at T+3 with slverr 0 and rdata 0. `paddr_o`/`pwdata_o` stable across SETUP and ACCESS.
- Read: addr 0x1, `pready_i` held low 3 ACCESS cycles, `prdata_i` = 0x0000_1234 → `rsp_valid_o` at T+6 with rdata 0x0000_1234.
- Error: write addr 0x2 with `pslverr_i` = 1 alongside `pready_i` → `rsp_slverr_o` = 1, `rsp_timeout_o` = 0.
- Backpressure: `rsp_ready_i` low for 5 cycles → response fields unchanged, `req_ready_o` = 0 throughout. A new `req_valid_i` is accepted only after RESP→IDLE.
- Timeout (macro on, TIMEOUT_CYCLES = 16): `pready_i` never asserts → abort after 16 ACCESS cycles with slverr 1, timeout 1, rdata 0. Repeat with `pready_i` in cycle 16 → normal completion.
- Reset mid-ACCESS: assert `resetn` low asynchronously → `psel_o`/`penable_o` drop before the next clock edge; no `rsp_valid_o`; after release `req_ready_o` = 1.
